// File: rtl/popcount_pkg.sv
// Shared constants, types and the mod-N adder used by the popcount31 unary
// stimulus generator and its rotate helper.
`default_nettype none

package popcount_pkg;

  localparam int PC_N  = 31;
  localparam int PC_CW = 5;

  typedef logic [PC_CW-1:0] pc_count_t;
  typedef logic [PC_N-1:0]  pc_vec_t;

  // (a + b) mod PC_N for a, b < PC_N: one compare-subtract, no divider.
  function automatic pc_count_t mod_add(input pc_count_t a, input pc_count_t b);
    logic [PC_CW:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum >= (PC_CW+1)'(PC_N))
      sum = sum - (PC_CW+1)'(PC_N);
    return sum[PC_CW-1:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/popcount_therm_rot.sv
// Combinational thermometer code of c ones, rotated left by offset modulo N.
// Revision: 1.0
`default_nettype none

module popcount_therm_rot #(
  parameter int N  = 31,
  parameter int CW = 5
) (
  input  logic [CW-1:0] c,       // already saturated to N
  input  logic [CW-1:0] offset,  // always < N
  output logic [N-1:0]  vec
);

  logic [N-1:0] therm;

  for (genvar i = 0; i < N; i++) begin : g_therm
    assign therm[i] = (CW'(i) < c);
  end

  // The upper half of the doubled, shifted code is the mod-N rotation.
  assign vec = N'(({therm, therm} << offset) >> N);

endmodule

`default_nettype wire

// File: rtl/popcount31_unary_gen.sv
// Count-to-unary stimulus source: one-deep valid/ready output stage with a
// rotating placement offset and a handshake counter.
// Revision: 1.0
`default_nettype none

module popcount31_unary_gen
  import popcount_pkg::*;
#(
  parameter int N    = PC_N,
  parameter int CW   = PC_CW,
  parameter int STEP = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [CW-1:0] in_count,
  input  logic          rot_en,
  input  logic          offset_clr,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_vec,
  output logic [CW-1:0] out_count,
  output logic [CW-1:0] out_offset,
  output logic [15:0]   emitted
);

  localparam logic [CW-1:0] N_CNT    = CW'(N);
  localparam logic [CW-1:0] STEP_CNT = CW'(STEP);

  logic          accept;
  logic          out_hs;
  logic [CW-1:0] count_sat;
  logic [CW-1:0] offset;
  logic [CW-1:0] offset_adv;
  logic [CW-1:0] offset_next;
  logic [N-1:0]  vec_next;

  assign in_ready  = !out_valid | out_ready;
  assign accept    = in_valid & in_ready;
  assign out_hs    = out_valid & out_ready;
  assign count_sat = (in_count > N_CNT) ? N_CNT : in_count;

  if (N == PC_N && CW == PC_CW) begin : g_pkg_add
    assign offset_adv = mod_add(offset, STEP_CNT);
  end else begin : g_gen_add
    logic [CW:0] sum;
    assign sum        = {1'b0, offset} + {1'b0, STEP_CNT};
    assign offset_adv = (sum >= (CW+1)'(N)) ? CW'(sum - (CW+1)'(N)) : sum[CW-1:0];
  end

  // A handshake completing on the same edge as an accept advances the offset
  // first, so back-to-back vectors step exactly like spaced-out ones.
  always_comb begin
    offset_next = offset;
    if (offset_clr)
      offset_next = '0;
    else if (out_hs && rot_en)
      offset_next = offset_adv;
  end

  popcount_therm_rot #(
    .N  (N),
    .CW (CW)
  ) u_therm_rot (
    .c      (count_sat),
    .offset (offset_next),
    .vec    (vec_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_vec    <= '0;
      out_count  <= '0;
      out_offset <= '0;
      emitted    <= '0;
      offset     <= '0;
    end else begin
      if (accept) begin
        out_valid  <= 1'b1;
        out_vec    <= vec_next;
        out_count  <= count_sat;
        out_offset <= offset_next;
      end else if (out_hs) begin
        out_valid  <= 1'b0;
      end
      if (out_hs)
        emitted <= emitted + 16'd1;
      offset <= offset_next;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_popcount31_unary_gen.sv
// Scoreboard bench for popcount31_unary_gen: cycle-stepped stimulus with a
// reference model of the offset, handshake and vector placement.
`default_nettype none

module tb_popcount31_unary_gen;

  localparam int N = 31;

  typedef struct packed {
    logic [30:0] vec;
    logic [4:0]  cnt;
    logic [4:0]  off;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_count = '0;
  logic        rot_en = 1'b0;
  logic        offset_clr = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [30:0] out_vec;
  logic [4:0]  out_count;
  logic [4:0]  out_offset;
  logic [15:0] emitted;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t q[$];
  exp_t cur;
  logic m_valid;
  int   m_off;
  logic [15:0] m_emit;
  logic m_ready;
  logic obs_ready;

  popcount31_unary_gen dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_count   (in_count),
    .rot_en     (rot_en),
    .offset_clr (offset_clr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_vec    (out_vec),
    .out_count  (out_count),
    .out_offset (out_offset),
    .emitted    (emitted)
  );

  always #5 clk = ~clk;

  function automatic exp_t make_exp(input logic [4:0] c, input int off);
    exp_t e;
    int   cs;
    cs    = (int'(c) > N) ? N : int'(c);
    e.vec = '0;
    for (int i = 0; i < cs; i++) e.vec[(i + off) % N] = 1'b1;
    e.cnt = cs[4:0];
    e.off = off[4:0];
    return e;
  endfunction

  task automatic model_reset();
    q.delete();
    cur     = '0;
    m_valid = 1'b0;
    m_off   = 0;
    m_emit  = '0;
  endtask

  // Drive one cycle of inputs, push the expected vector on accept, pop it
  // when it reaches the outputs.
  task automatic step(input logic v, input logic [4:0] c, input logic re,
                      input logic clr, input logic ordy);
    logic hs, acc;
    int   off_next;
    @(negedge clk);
    in_valid = v; in_count = c; rot_en = re; offset_clr = clr; out_ready = ordy;
    #1;
    obs_ready = in_ready;
    hs        = m_valid & ordy;
    m_ready   = !m_valid | ordy;
    acc       = v & m_ready;
    off_next  = clr ? 0 : ((hs && re) ? (m_off + 1) % N : m_off);
    if (acc) q.push_back(make_exp(c, off_next));
    @(posedge clk);
    #1;
    if (hs) m_emit = m_emit + 16'd1;
    m_off = off_next;
    if (acc) begin
      cur     = q.pop_front();
      m_valid = 1'b1;
    end else if (hs) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    model_reset();
    n_vec++;
    if ({out_valid, out_vec, out_count, out_offset, emitted} !== '0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset: valid=%b vec=%h cnt=%0d off=%0d emitted=%0d in_ready=%b, want all 0 and in_ready=1",
               out_valid, out_vec, out_count, out_offset, emitted, in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_fixed();
    for (int k = 0; k < 2; k++) begin
      step(1'b1, 5'd3, 1'b0, 1'b0, 1'b1);
      n_vec++;
      if (out_valid !== 1'b1 || out_vec !== 31'h0000_0007 || out_count !== 5'd3 || out_offset !== 5'd0) begin
        n_err++;
        $display("FAIL fixed_%0d: valid=%b vec=%h cnt=%0d off=%0d, want 1 00000007 3 0",
                 k, out_valid, out_vec, out_count, out_offset);
      end
    end
    step(1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    n_vec++;
    if (out_valid !== 1'b0 || emitted !== m_emit) begin
      n_err++;
      $display("FAIL fixed_drain: valid=%b emitted=%0d, want 0 %0d", out_valid, emitted, m_emit);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] e0;
    logic [30:0] want [2];
    want[0] = 31'h0000_0007;
    want[1] = 31'h0000_000E;
    e0 = emitted;
    for (int k = 0; k < 2; k++) begin
      step(1'b1, 5'd3, 1'b1, 1'b0, 1'b1);
      n_vec++;
      if (out_valid !== 1'b1 || out_vec !== want[k] || out_vec !== cur.vec || out_offset !== cur.off) begin
        n_err++;
        $display("FAIL b2b_%0d: valid=%b vec=%h off=%0d, want 1 %h %0d",
                 k, out_valid, out_vec, out_offset, want[k], cur.off);
      end
    end
    step(1'b0, 5'd0, 1'b1, 1'b0, 1'b1);
    n_vec++;
    if (emitted !== e0 + 16'd2) begin
      n_err++;
      $display("FAIL b2b_emitted: got %0d want %0d", emitted, e0 + 16'd2);
    end
  endtask

  task automatic test_wrap();
    step(1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 30; k++) begin
      step(1'b1, 5'(k % 32), 1'b1, 1'b0, 1'b1);
      n_vec++;
      if ({out_valid, out_vec, out_count, out_offset, emitted} !== {m_valid, cur.vec, cur.cnt, cur.off, m_emit}) begin
        n_err++;
        $display("FAIL wrap_stream_%0d: vec=%h cnt=%0d off=%0d em=%0d, want %h %0d %0d %0d",
                 k, out_vec, out_count, out_offset, emitted, cur.vec, cur.cnt, cur.off, m_emit);
      end
    end
    step(1'b1, 5'd2, 1'b1, 1'b0, 1'b1);
    n_vec++;
    if (out_vec !== 31'h4000_0001 || out_offset !== 5'd30 || out_count !== 5'd2) begin
      n_err++;
      $display("FAIL wrap_edge: vec=%h off=%0d cnt=%0d, want 40000001 30 2", out_vec, out_offset, out_count);
    end
    step(1'b0, 5'd0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 5'd1, 1'b0, 1'b0, 1'b1);
    n_vec++;
    if (out_vec !== 31'h0000_0001 || out_offset !== 5'd0) begin
      n_err++;
      $display("FAIL wrap_after: vec=%h off=%0d, want 00000001 0", out_vec, out_offset);
    end
  endtask

  task automatic test_extremes();
    step(1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 17; k++) step(1'b1, 5'd9, 1'b1, 1'b0, 1'b1);
    step(1'b1, 5'd0, 1'b1, 1'b0, 1'b1);
    n_vec++;
    if (out_vec !== 31'h0 || out_offset !== 5'd17 || $countones(out_vec) !== int'(out_count)) begin
      n_err++;
      $display("FAIL zero_at17: vec=%h off=%0d cnt=%0d, want 00000000 17 0", out_vec, out_offset, out_count);
    end
    step(1'b1, 5'd31, 1'b0, 1'b0, 1'b1);
    n_vec++;
    if (out_vec !== 31'h7FFF_FFFF || out_offset !== 5'd17 || $countones(out_vec) !== int'(out_count)) begin
      n_err++;
      $display("FAIL full_at17: vec=%h off=%0d cnt=%0d, want 7fffffff 17 31", out_vec, out_offset, out_count);
    end
  endtask

  task automatic test_stall();
    logic [30:0] held_vec;
    logic [4:0]  held_off;
    logic [15:0] e0;
    held_vec = out_vec;
    held_off = out_offset;
    e0       = emitted;
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
      n_vec++;
      if (obs_ready !== 1'b0 || out_valid !== 1'b1 || out_vec !== held_vec || out_offset !== held_off) begin
        n_err++;
        $display("FAIL stall_%0d: in_ready=%b valid=%b vec=%h off=%0d, want 0 1 %h %0d",
                 k, obs_ready, out_valid, out_vec, out_offset, held_vec, held_off);
      end
    end
    step(1'b1, 5'd5, 1'b1, 1'b0, 1'b1);
    n_vec++;
    if (obs_ready !== 1'b1 || emitted !== e0 + 16'd1 || out_offset !== 5'd18 ||
        out_vec !== cur.vec || out_count !== 5'd5) begin
      n_err++;
      $display("FAIL stall_release: in_ready=%b em=%0d off=%0d vec=%h cnt=%0d, want 1 %0d 18 %h 5",
               obs_ready, emitted, out_offset, out_vec, out_count, e0 + 16'd1, cur.vec);
    end
  endtask

  task automatic test_clr();
    step(1'b0, 5'd0, 1'b1, 1'b1, 1'b1);
    step(1'b1, 5'd4, 1'b0, 1'b0, 1'b1);
    n_vec++;
    if (out_vec !== 31'h0000_000F || out_offset !== 5'd0 || emitted !== m_emit) begin
      n_err++;
      $display("FAIL clr_priority: vec=%h off=%0d em=%0d, want 0000000f 0 %0d", out_vec, out_offset, emitted, m_emit);
    end
  endtask

  task automatic test_rst_mid();
    step(1'b1, 5'd6, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    out_ready = 1'b0;
    rst = 1'b1;
    #1;
    model_reset();
    n_vec++;
    if (out_valid !== 1'b0 || emitted !== 16'd0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL rst_mid: valid=%b emitted=%0d in_ready=%b, want 0 0 1", out_valid, emitted, in_ready);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(1'b1, 5'd3, 1'b1, 1'b0, 1'b1);
    n_vec++;
    if (out_valid !== 1'b1 || out_vec !== 31'h0000_0007 || out_offset !== 5'd0 || emitted !== 16'd0) begin
      n_err++;
      $display("FAIL rst_first: valid=%b vec=%h off=%0d em=%0d, want 1 00000007 0 0",
               out_valid, out_vec, out_offset, emitted);
    end
  endtask

  initial begin
    test_reset();
    test_fixed();
    test_back_to_back();
    test_wrap();
    test_extremes();
    test_stall();
    test_clr();
    test_rst_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
